// File: rtl/nibble_serial_adder_ctrl.sv
// Multi-cycle add/subtract controller: one 4-bit ripple adder is reused to
// process WIDTH-bit operands one nibble per clock, least-significant first.

module adder4 (
   input  logic [3:0] i_a,
   input  logic [3:0] i_b,
   input  logic       i_c,
   output logic [3:0] o_s,
   output logic       o_c
);
   logic [4:0] w_c;

   always_comb begin
      w_c    = '0;
      o_s    = '0;
      w_c[0] = i_c;
      for (int unsigned i = 0; i < 4; i++) begin
         o_s[i]   = i_a[i] ^ i_b[i] ^ w_c[i];
         w_c[i+1] = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
      end
      o_c = w_c[4];
   end
endmodule

module nibble_serial_adder_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             Start,
   input  logic             Sub,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Sum,
   output logic             Cout,
   output logic             Overflow
);
   localparam int N  = WIDTH / 4;
   localparam int IW = (N > 1) ? $clog2(N) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]       r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic             r_carry;
   logic [IW-1:0]    r_idx;
   logic [WIDTH-1:0] r_sum;
   logic             r_cout;
   logic             r_ovf;

   logic [3:0]       w_na;
   logic [3:0]       w_nb;
   logic [3:0]       w_s;
   logic             w_co;

   assign w_na = r_a[{r_idx, 2'b00} +: 4];
   assign w_nb = r_b[{r_idx, 2'b00} +: 4];

   adder4 u_adder4 (
      .i_a (w_na),
      .i_b (w_nb),
      .i_c (r_carry),
      .o_s (w_s),
      .o_c (w_co)
   );

   // Subtraction is A + ~B + 1: B is inverted at capture and the +1 enters as the initial carry.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state <= S_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_carry <= 1'b0;
         r_idx   <= '0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (Start) begin
                  r_a     <= A;
                  r_b     <= Sub ? ~B : B;
                  r_carry <= Sub;
                  r_idx   <= '0;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_sum[{r_idx, 2'b00} +: 4] <= w_s;
               r_carry <= w_co;
               r_idx   <= r_idx + 1'b1;
               if (r_idx == LAST_IDX) begin
                  r_cout  <= w_co;
                  r_ovf   <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_s[3] != r_a[WIDTH-1]);
                  r_state <= S_DONE;
               end
            end
            S_DONE:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign Busy     = (r_state == S_RUN);
   assign Done     = (r_state == S_DONE);
   assign Sum      = r_sum;
   assign Cout     = r_cout;
   assign Overflow = r_ovf;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Scoreboard bench for nibble_serial_adder_ctrl: directed operations on a
// 16-bit and a 4-bit instance, results checked by monitors on each Done.

module tb_nibble_serial_adder_ctrl;
   logic        Clk = 1'b0;
   logic        Reset_n;
   logic        Start, Sub, Busy, Done, Cout, Overflow;
   logic [15:0] A, B, Sum;
   logic        Start4, Sub4, Busy4, Done4, Cout4, Overflow4;
   logic [3:0]  A4, B4, Sum4;

   int n_cmp = 0;
   int n_bad = 0;

   logic [17:0] q16[$];
   logic [5:0]  q4[$];

   always #5 Clk = ~Clk;

   nibble_serial_adder_ctrl #(.WIDTH(16)) u_dut16 (
      .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Sub(Sub), .A(A), .B(B),
      .Busy(Busy), .Done(Done), .Sum(Sum), .Cout(Cout), .Overflow(Overflow)
   );

   nibble_serial_adder_ctrl #(.WIDTH(4)) u_dut4 (
      .Clk(Clk), .Reset_n(Reset_n), .Start(Start4), .Sub(Sub4), .A(A4), .B(B4),
      .Busy(Busy4), .Done(Done4), .Sum(Sum4), .Cout(Cout4), .Overflow(Overflow4)
   );

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // 16-bit result monitor
   always @(negedge Clk) begin
      if (Done === 1'b1) begin
         if (q16.size() == 0) begin
            check("unexpected_done16", 32'd1, 32'd0);
         end else begin
            logic [17:0] e;
            e = q16.pop_front();
            check("sum16",  32'(Sum), 32'(e[17:2]));
            check("cout16", 32'(Cout), 32'(e[1]));
            check("ovf16",  32'(Overflow), 32'(e[0]));
         end
      end
   end

   // 4-bit result monitor
   always @(negedge Clk) begin
      if (Done4 === 1'b1) begin
         if (q4.size() == 0) begin
            check("unexpected_done4", 32'd1, 32'd0);
         end else begin
            logic [5:0] e;
            e = q4.pop_front();
            check("sum4",  32'(Sum4), 32'(e[5:2]));
            check("cout4", 32'(Cout4), 32'(e[1]));
            check("ovf4",  32'(Overflow4), 32'(e[0]));
         end
      end
   end

   task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                        input logic [15:0] es, input logic ec, input logic eo);
      int cnt;
      int busy;
      @(negedge Clk);
      A = a; B = b; Sub = sub; Start = 1'b1;
      q16.push_back({es, ec, eo});
      @(negedge Clk);
      Start = 1'b0; A = ~a; B = ~b; Sub = ~sub;
      cnt = 0; busy = 0;
      while (Done !== 1'b1 && cnt < 20) begin
         if (Busy === 1'b1) busy++;
         @(negedge Clk);
         cnt++;
      end
      check("done_latency", 32'(cnt), 32'd4);
      check("busy_cycles", 32'(busy), 32'd4);
      check("busy_at_done", 32'(Busy), 32'd0);
      @(negedge Clk);
      check("done_pulse_end", 32'(Done), 32'd0);
      check("sum_hold", 32'(Sum), 32'(es));
   endtask

   task automatic do_op4(input logic [3:0] a, input logic [3:0] b, input logic sub,
                         input logic [3:0] es, input logic ec, input logic eo);
      @(negedge Clk);
      A4 = a; B4 = b; Sub4 = sub; Start4 = 1'b1;
      q4.push_back({es, ec, eo});
      @(negedge Clk);
      Start4 = 1'b0;
      check("busy4_run", 32'(Busy4), 32'd1);
      check("done4_run", 32'(Done4), 32'd0);
      @(negedge Clk);
      check("done4_next", 32'(Done4), 32'd1);
      check("busy4_done", 32'(Busy4), 32'd0);
      @(negedge Clk);
      check("done4_end", 32'(Done4), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      Reset_n = 1'b1;
      Start = 1'b0; Sub = 1'b0; A = '0; B = '0;
      Start4 = 1'b0; Sub4 = 1'b0; A4 = '0; B4 = '0;
      #2 Reset_n = 1'b0;
      #1;
      check("rst_busy", 32'(Busy), 32'd0);
      check("rst_done", 32'(Done), 32'd0);
      check("rst_sum", 32'(Sum), 32'd0);
      check("rst_cout", 32'(Cout), 32'd0);
      check("rst_ovf", 32'(Overflow), 32'd0);
      check("rst_sum4", 32'(Sum4), 32'd0);
      repeat (2) @(negedge Clk);
      Reset_n = 1'b1;

      do_op(16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
      do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
      do_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
      do_op(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      do_op(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

      // Start held high, operands changing every cycle; captures at k = 0, 6, 12
      for (int k = 0; k < 18; k++) begin
         @(negedge Clk);
         check("b2b_done", 32'(Done), (k % 6 == 5) ? 32'd1 : 32'd0);
         A = 16'(16'h0100 * k + 16'h0011);
         B = 16'(16'h0A00 - k);
         Sub = 1'b0;
         Start = 1'b1;
         if (k == 0)  q16.push_back({16'h0A11, 1'b0, 1'b0});
         if (k == 6)  q16.push_back({16'h100B, 1'b0, 1'b0});
         if (k == 12) q16.push_back({16'h1605, 1'b0, 1'b0});
      end
      @(negedge Clk);
      Start = 1'b0;

      // Abort after two nibbles; previous Sum 0x1605, low byte becomes 0xFE
      @(negedge Clk);
      A = 16'hFFFF; B = 16'hFFFF; Sub = 1'b0; Start = 1'b1;
      @(negedge Clk);
      Start = 1'b0;
      @(negedge Clk);
      @(negedge Clk);
      check("partial_sum", 32'(Sum), 32'h16FE);
      check("partial_busy", 32'(Busy), 32'd1);
      Reset_n = 1'b0;
      #1;
      check("abort_sum", 32'(Sum), 32'd0);
      check("abort_busy", 32'(Busy), 32'd0);
      check("abort_done", 32'(Done), 32'd0);
      check("abort_cout", 32'(Cout), 32'd0);
      check("abort_ovf", 32'(Overflow), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge Clk);
         check("abort_no_done", 32'(Done), 32'd0);
      end
      Reset_n = 1'b1;
      do_op(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);

      do_op4(4'h9, 4'h8, 1'b0, 4'h1, 1'b1, 1'b1);
      do_op4(4'h3, 4'h5, 1'b1, 4'hE, 1'b0, 1'b0);

      repeat (2) @(negedge Clk);
      check("q16_drained", 32'(q16.size()), 32'd0);
      check("q4_drained", 32'(q4.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
Multi-cycle add/subtract controller that reuses a single 4-bit ripple adder (one adder4 instance) to process WIDTH-bit operands one nibble per clock, least-significant nibble first. It latches the operands, steps a nibble index, and holds the carry in a flop between cycles. It returns the sum, carry-out and signed overflow with a Start/Done handshake. It sits beside the datapath ALU wherever area matters more than single-cycle latency.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4; N = WIDTH/4 nibble steps

Ports:
Clk  in  1  system clock, all state updates on rising edge
Reset_n  in  1  asynchronous, active-low reset
Start  in  1  request a new operation; sampled only in IDLE
Sub  in  1  0 = A+B, 1 = A-B; sampled with Start
A  in  WIDTH  operand A; sampled with Start
B  in  WIDTH  operand B; sampled with Start
Busy  out  1  high while in RUN
Done  out  1  one-cycle pulse, high while in DONE
Sum  out  WIDTH  result register; holds last result until the next RUN writes it
Cout  out  1  final carry-out; for Sub, 1 = no borrow (A >= B unsigned)
Overflow  out  1  two's-complement signed overflow of the last operation

Behaviour:
- Reset (Reset_n low, asynchronous): state=IDLE; Busy=0, Done=0, Sum=0, Cout=0, Overflow=0; internal operand regs, carry flop and nibble index cleared. Reset mid-RUN aborts the operation; no Done is produced.
- States: IDLE, RUN, DONE.
- IDLE: on an edge with Start=1:
  - A_reg<=A, B_reg<=(Sub ? ~B : B), carry<=Sub, idx<=0.
  - State->RUN.
  - The Sum/Cout/Overflow registers are not cleared; they keep their old values until overwritten.
- RUN, each edge:
  - The adder4 inputs are nibble idx of A_reg and of B_reg, with c_in=carry.
  - Sum[4*idx+3:4*idx] <= S; carry <= c_out; idx <= idx+1.
- RUN, edge where idx==N-1, in addition to the nibble write:
  - Cout <= c_out.
  - Overflow <= (A_reg[WIDTH-1]==B_reg[WIDTH-1]) && (S[3]!=A_reg[WIDTH-1]), where B_reg is the effective (possibly inverted) operand.
  - State->DONE.
- DONE: Done=1 for exactly one cycle; next edge -> IDLE unconditionally. Start during DONE is ignored and not queued.
- Start during RUN is ignored. A, B and Sub may change freely after the sampling edge.
- Latency: Start sampled at edge E0. Nibbles are processed at E1..EN. Done is high in the cycle following EN. The next Start can be sampled at E(N+2).
- Start held high continuously gives back-to-back operations with a period of N+2 cycles.
- Sum updates nibble by nibble during RUN, so it is only valid while Done=1 and afterwards until the next Start is accepted.
- Arithmetic is modulo 2^WIDTH. Carry propagates only through the carry flop; no combinational path from A/B to outputs.
- idx width = max(1, clog2(N)). For WIDTH=4, RUN lasts one cycle.

Test Plan:
- WIDTH=16, Sub=0, A=0x1234, B=0x0FFF, Start pulsed one cycle -> Busy high for 4 cycles, Done one-cycle pulse 5 cycles after the Start edge, Sum=0x2233, Cout=0, Overflow=0.
- A=0xFFFF, B=0x0001, Sub=0 -> Sum=0x0000, Cout=1, Overflow=0; A=0x7FFF, B=0x0001 -> Sum=0x8000, Cout=0, Overflow=1.
- Sub=1, A=0x0005, B=0x0007 -> Sum=0xFFFE, Cout=0, Overflow=0; Sub=1, A=0x8000, B=0x0001 -> Sum=0x7FFF, Cout=1, Overflow=1.
- Start held high with A/B changed every cycle -> operands captured only at IDLE edges, Done pulses every 6 cycles, and each result matches the operands present at its capture edge.
- Reset_n asserted low mid-RUN (after 2 nibbles) -> all outputs 0 immediately (asynchronously), no Done; after release, a new Start with 0x00FF+0x0001 yields Sum=0x0100.
- WIDTH=4 instance: A=0x9, B=0x8, Sub=0 -> Done in the cycle after the first RUN edge, Sum=0x1, Cout=1, Overflow=1.
